// File: rtl/regfile_port_arbiter.sv
// Register-file port arbiter: owns write port 3 and shares read port 2
// between the single-cycle core and a debug requester. After reset it
// clears x1..REG_COUNT-1 through the write port while the core is stalled.
module regfile_port_arbiter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned REG_COUNT  = 32,
    parameter int unsigned MAX_WAIT   = 8
) (
    input  logic                  CLK,
    input  logic                  rst_n,

    input  logic                  core_we,
    input  logic [ADDR_WIDTH-1:0] core_a3,
    input  logic [DATA_WIDTH-1:0] core_wd3,
    input  logic [ADDR_WIDTH-1:0] core_a2,
    input  logic                  core_rs2_en,
    output logic                  core_stall,
    output logic                  init_done,

    input  logic                  dbg_req,
    input  logic                  dbg_we,
    input  logic [ADDR_WIDTH-1:0] dbg_addr,
    input  logic [DATA_WIDTH-1:0] dbg_wdata,
    output logic                  dbg_ack,
    output logic [DATA_WIDTH-1:0] dbg_rdata,

    output logic                  rf_we3,
    output logic [ADDR_WIDTH-1:0] rf_a3,
    output logic [DATA_WIDTH-1:0] rf_wd3,
    output logic [ADDR_WIDTH-1:0] rf_a2,
    input  logic [DATA_WIDTH-1:0] rf_rd2
);

    localparam int unsigned           WAIT_W   = $clog2(MAX_WAIT + 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(REG_COUNT - 1);
    localparam logic [WAIT_W-1:0]     WAIT_MAX = WAIT_W'(MAX_WAIT);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_SERVE = 2'd2,
        ST_ACK   = 2'd3
    } state_e;

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] init_cnt_q;
    logic [WAIT_W-1:0]     wait_cnt_q;
    logic                  dbg_ack_q;
    logic [DATA_WIDTH-1:0] dbg_rdata_q;
    logic                  init_done_q;

    logic                  dbg_free;
    logic                  dbg_force;
    logic                  dbg_grant;

    // Debug gets the port when the core leaves it idle, or by force after MAX_WAIT waits
    always_comb begin
        dbg_free  = dbg_we ? !core_we : !core_rs2_en;
        dbg_force = (wait_cnt_q == WAIT_MAX);
        dbg_grant = (state_q == ST_SERVE) && (dbg_free || dbg_force);
    end

    // Register-file port steering and core stall
    always_comb begin
        rf_we3     = core_we && (core_a3 != '0);
        rf_a3      = core_a3;
        rf_wd3     = core_wd3;
        rf_a2      = core_a2;
        core_stall = 1'b0;
        if (!rst_n) begin
            rf_we3     = 1'b0;
            core_stall = 1'b1;
        end else if (state_q == ST_INIT) begin
            rf_we3     = 1'b1;
            rf_a3      = init_cnt_q;
            rf_wd3     = '0;
            core_stall = 1'b1;
        end else if (dbg_grant) begin
            core_stall = dbg_force && !dbg_free;
            if (dbg_we) begin
                rf_we3 = (dbg_addr != '0);
                rf_a3  = dbg_addr;
                rf_wd3 = dbg_wdata;
            end else begin
                rf_a2 = dbg_addr;
                // A stalled core re-presents its write next cycle, so drop it now
                if (core_stall) begin
                    rf_we3 = 1'b0;
                end
            end
        end
    end

    // Sequencer: init sweep, debug request tracking, ack and read-data capture
    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            state_q     <= ST_INIT;
            init_cnt_q  <= ADDR_WIDTH'(1);
            wait_cnt_q  <= '0;
            dbg_ack_q   <= 1'b0;
            dbg_rdata_q <= '0;
            init_done_q <= 1'b0;
        end else begin
            dbg_ack_q <= 1'b0;
            case (state_q)
                ST_INIT: begin
                    if (init_cnt_q == LAST_IDX) begin
                        state_q     <= ST_IDLE;
                        init_done_q <= 1'b1;
                    end else begin
                        init_cnt_q <= init_cnt_q + ADDR_WIDTH'(1);
                    end
                end
                ST_IDLE: begin
                    if (dbg_req) begin
                        state_q    <= ST_SERVE;
                        wait_cnt_q <= '0;
                    end
                end
                ST_SERVE: begin
                    if (dbg_grant) begin
                        state_q   <= ST_ACK;
                        dbg_ack_q <= 1'b1;
                        if (!dbg_we) begin
                            dbg_rdata_q <= rf_rd2;
                        end
                    end else begin
                        wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
                    end
                end
                ST_ACK: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_INIT;
                end
            endcase
        end
    end

    assign dbg_ack   = dbg_ack_q;
    assign dbg_rdata = dbg_rdata_q;
    assign init_done = init_done_q;

endmodule

// File: doc/regfile_port_arbiter.md
Name: regfile_port_arbiter

Overview:
- Owns the register file's write port (port 3) and shares read port 2 between the core datapath and a debug requester.
- After reset it runs an init sweep that clears x1..x31 through the write port, holding the core stalled.
- In normal operation the core has priority. Debug accesses go in idle slots, and a starvation counter forces a one-cycle core stall when debug has waited too long.
- Sits between the single-cycle core, the debug module and the register file.

Parameters:
DATA_WIDTH, 32, register width
ADDR_WIDTH, 5, register address width
REG_COUNT, 32, registers swept by init (x1..REG_COUNT-1)
MAX_WAIT, 8, debug wait cycles before a forced core stall (≥1)

Ports:
CLK  in  1  clock; all state on rising edge
rst_n  in  1  reset, synchronous, active-low
core_we  in  1  core write-back enable
core_a3  in  ADDR_WIDTH  core write address
core_wd3  in  DATA_WIDTH  core write data
core_a2  in  ADDR_WIDTH  core rs2 address
core_rs2_en  in  1  core uses read port 2 this cycle
core_stall  out  1  core must not commit/advance PC this cycle
init_done  out  1  init sweep finished
dbg_req  in  1  debug request, held until dbg_ack
dbg_we  in  1  1=write, 0=read; stable while dbg_req
dbg_addr  in  ADDR_WIDTH  debug register address
dbg_wdata  in  DATA_WIDTH  debug write data
dbg_ack  out  1  one-cycle completion pulse
dbg_rdata  out  DATA_WIDTH  read data, valid with dbg_ack
rf_we3  out  1  to register file WE3
rf_a3  out  ADDR_WIDTH  to A3
rf_wd3  out  DATA_WIDTH  to WD3
rf_a2  out  ADDR_WIDTH  to A2
rf_rd2  in  DATA_WIDTH  from RD2 (combinational read)

Behaviour:
- States: INIT, IDLE, SERVE, ACK. Registered: state, init_cnt, wait_cnt, dbg_ack, dbg_rdata, init_done.
- Reset (rst_n=0 at edge):
  - Next state INIT, init_cnt=1, wait_cnt=0.
  - dbg_ack=0, dbg_rdata=0, init_done=0.
  - While rst_n=0, rf_we3 is forced 0 and core_stall=1.
  - Reset mid-transaction drops the pending debug access with no ack.
- INIT:
  - rf_we3=1, rf_a3=init_cnt, rf_wd3=0, core_stall=1.
  - init_cnt increments each cycle. At init_cnt=REG_COUNT-1 the state goes to IDLE and init_done=1 (sticky until reset).
  - Sweep takes REG_COUNT-1 cycles. dbg_req is ignored.
- Pass-through (IDLE, ACK, and SERVE when not granted):
  - rf_we3 = core_we & (core_a3≠0); rf_a3=core_a3; rf_wd3=core_wd3; rf_a2=core_a2; core_stall=0.
- IDLE: if dbg_req, go to SERVE next cycle, wait_cnt=0.
- SERVE, grant condition:
  - free = dbg_we ? !core_we : !core_rs2_en.
  - force = (wait_cnt==MAX_WAIT).
  - grant = free | force.
- SERVE on grant:
  - Write: rf_we3=(dbg_addr≠0), rf_a3=dbg_addr, rf_wd3=dbg_wdata.
  - Read: rf_a2=dbg_addr, and dbg_rdata←rf_rd2 at the edge.
  - core_stall = force & !free. A stalled core's write and read are discarded and the core re-presents them next cycle.
  - Next state ACK, dbg_ack←1.
- SERVE without grant: wait_cnt increments, stay in SERVE.
- ACK:
  - dbg_ack=1 for exactly this cycle, with dbg_rdata valid (held until the next read).
  - Next state IDLE, and dbg_req is ignored this cycle.
  - The requester deasserts dbg_req in the ACK cycle. If it is still high in IDLE, that starts a new transaction.
- Latency: minimum request-to-ack is 2 cycles (IDLE→SERVE grant→ACK). Worst case is MAX_WAIT+2 cycles.
- Debug write to x0 completes and acks, but rf_we3 stays 0. Debug read of x0 returns whatever rf_rd2 gives, expected 0.
- A core write and a debug read in the same cycle are both served, since they use separate ports (a debug write never overlaps core_we).

Test Plan:
- Reset low 2 cycles, then high → INIT for 31 cycles writing rf_a3=1..31 with wd 0 and core_stall=1; init_done=1 from cycle 32; reading x5 afterward gives 0.
- IDLE, core_we=0, debug write x7=0xDEADBEEF → rf_we3 pulse with a3=7 one cycle after req, dbg_ack next cycle; debug read x7 → dbg_rdata=0xDEADBEEF with ack.
- core_we=1 every cycle, debug write x3=0x55 → waits exactly 8 cycles; on the 9th SERVE cycle core_stall=1, rf_a3=3, rf_wd3=0x55; ack the following cycle.
- core_rs2_en=1 with core_we=1 alternating 0, debug read x9 → granted on the first cycle with core_rs2_en=0; core_stall never asserted.
- Debug write x0=0x1234 → dbg_ack asserted, rf_we3 stays 0; subsequent read of x0 returns 0.
- rst_n low during SERVE → no dbg_ack; state INIT; dbg_req held high is ignored until init_done, then served.
